uart_tx_engine: RTL

//  - UART transmit engine; the transmit-side counterpart of the receive remap path.
//  - Takes an 8-bit byte from out_port on a load strobe and frames it per eight/pen/ohel.
//  - Serialises the frame LSB-first on tx at a programmable bit period.
//  - Sits between the processor output port and the serial pin.

---
 rtl/uart_tx_engine.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmit serialiser.
// Takes a byte on a load strobe and frames it as 11 bit-times, LSB first:
// a start bit, 7 or 8 data bits, an optional parity bit, then stop bits
// (unused tail slots are padded with 1). Each bit is held baud_k clocks.
// Optional feature macro: UART_TX_HOLD_EN adds a one-deep holding register
// so the next byte can be queued while a frame is still on the line.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | line idle (tx=1), waiting for an accepted load
//  S_SHIFT | frame on the line, baud/bit counters running

module uart_tx_engine #(
  parameter int BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BAUD_W-1:0] baud_k,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic              load,
  input  logic [7:0]        out_port,
  output logic              tx,
  output logic              tx_rdy,
  output logic              tx_done
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [10:0] FRAME_IDLE = 11'h7FF;
  localparam logic [3:0]  LAST_BIT   = 4'd10;

  state_t            state_q;
  logic [10:0]       shift_q;
  logic [BAUD_W-1:0] baud_cnt_q;
  logic [3:0]        bit_cnt_q;
  logic              tx_rdy_q;
  logic              tx_done_q;

  logic [BAUD_W-1:0] baud_last;
  logic              baud_term;
  logic              frame_end;
  logic              accept;
  logic [10:0]       frame_d;

`ifdef UART_TX_HOLD_EN
  logic [7:0]        hold_data_q;
  logic              hold_eight_q;
  logic              hold_pen_q;
  logic              hold_ohel_q;
  logic              hold_full_q;
  logic [10:0]       hold_frame_d;
`endif

  // Assemble the 11-bit line image (bit 0 goes out first).
  function automatic logic [10:0] build_frame(input logic [7:0] d,
                                              input logic       e,
                                              input logic       p,
                                              input logic       o);
    logic        par;
    logic [10:0] f;
    if (e) begin
      par = (^d) ^ o;
      f   = p ? {1'b1, par, d, 1'b0} : {2'b11, d, 1'b0};
    end else begin
      par = (^d[6:0]) ^ o;
      f   = p ? {2'b11, par, d[6:0], 1'b0} : {3'b111, d[6:0], 1'b0};
    end
    return f;
  endfunction

  // Bit-period compare and frame assembly; divisors 0/1 behave as 2.
  // The >= compare keeps a mid-frame baud_k reduction from running the
  // counter through a full wrap.
  always_comb begin
    baud_last = (baud_k < BAUD_W'(2)) ? BAUD_W'(1) : (baud_k - BAUD_W'(1));
    baud_term = (baud_cnt_q >= baud_last);
    frame_end = (state_q == S_SHIFT) && baud_term && (bit_cnt_q == LAST_BIT);
    accept    = load && tx_rdy_q;
    frame_d   = build_frame(out_port, eight, pen, ohel);
`ifdef UART_TX_HOLD_EN
    hold_frame_d = build_frame(hold_data_q, hold_eight_q, hold_pen_q, hold_ohel_q);
`endif
  end

  // Transmit FSM: load, bit timing, shifting and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shift_q    <= FRAME_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_rdy_q   <= 1'b1;
      tx_done_q  <= 1'b0;
`ifdef UART_TX_HOLD_EN
      hold_data_q  <= '0;
      hold_eight_q <= 1'b0;
      hold_pen_q   <= 1'b0;
      hold_ohel_q  <= 1'b0;
      hold_full_q  <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            shift_q    <= frame_d;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            state_q    <= S_SHIFT;
`ifndef UART_TX_HOLD_EN
            tx_rdy_q   <= 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          if (!baud_term) begin
            baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
          end else if (bit_cnt_q != LAST_BIT) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= bit_cnt_q + 4'd1;
            shift_q    <= {1'b1, shift_q[10:1]};
          end else begin
            tx_done_q  <= 1'b1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
`ifdef UART_TX_HOLD_EN
            // A queued byte starts on this same edge: no idle gap.
            if (hold_full_q) begin
              shift_q     <= hold_frame_d;
              hold_full_q <= 1'b0;
              tx_rdy_q    <= 1'b1;
            end else if (accept) begin
              shift_q <= frame_d;
            end else begin
              shift_q <= FRAME_IDLE;
              state_q <= S_IDLE;
            end
`else
            shift_q  <= FRAME_IDLE;
            tx_rdy_q <= 1'b1;
            state_q  <= S_IDLE;
`endif
          end
`ifdef UART_TX_HOLD_EN
          // A load landing exactly on the frame end went straight to the
          // shift register above, so only mid-frame loads fill the hold.
          if (accept && !frame_end) begin
            hold_data_q  <= out_port;
            hold_eight_q <= eight;
            hold_pen_q   <= pen;
            hold_ohel_q  <= ohel;
            hold_full_q  <= 1'b1;
            tx_rdy_q     <= 1'b0;
          end
`endif
        end
      endcase
    end
  end

  assign tx      = shift_q[0];
  assign tx_rdy  = tx_rdy_q;
  assign tx_done = tx_done_q;

endmodule
